// File: rtl/ck_rst_pkg.sv
// Shared types and helpers for the reset/enable sequencer.
// Holds the FSM state encoding and the counter width helper.
package ck_rst_pkg;

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_WAIT = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  // Counter must hold the larger of the hold and the last enable offset.
  function automatic int cnt_width(input int a, input int b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/rst_sync.sv
// Reset synchroniser: asynchronous assertion, synchronous deassertion.
// The chain clears on rst_n low and shifts in ones on each clk edge.
module rst_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic rst_sync
);

  logic [SYNC_STAGES-1:0] sync_r;

  // Shift chain cleared asynchronously, filled with ones synchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_sync = sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/ck_rst_seq.sv
// Reset and enable sequencer: holds rst_n_out low, then releases staggered
// enables and a divided pixel tick; soft_rst re-runs the whole sequence.
module ck_rst_seq
  import ck_rst_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int RST_HOLD    = 5,
  parameter int EN_DELAY    = 5,
  parameter int N_CH        = 2,
  parameter int EN_STAGGER  = 1,
  parameter int DIV         = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            soft_rst,
  output logic            rst_n_out,
  output logic [N_CH-1:0] en,
  output logic            tick,
  output logic            done
);

  localparam int LAST  = EN_DELAY - 1 + (N_CH - 1) * EN_STAGGER;
  localparam int CNT_W = cnt_width(RST_HOLD, EN_DELAY + (N_CH - 1) * EN_STAGGER);
  localparam int DIV_W = $clog2(DIV) + 1;

  logic             rst_sync_s;
  logic             soft_rst_r;
  state_t           state_r,     state_nxt_s;
  logic [CNT_W-1:0] cnt_r,       cnt_nxt_s;
  logic [DIV_W-1:0] divcnt_r,    divcnt_nxt_s;
  logic             rst_n_out_r, rst_n_out_nxt_s;
  logic [N_CH-1:0]  en_r,        en_nxt_s;
  logic             tick_r,      tick_nxt_s;
  logic             done_r,      done_nxt_s;

  rst_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rst_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .rst_sync (rst_sync_s)
  );

  // Next-state, counter, enable and divider logic
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    rst_n_out_nxt_s = rst_n_out_r;
    en_nxt_s        = en_r;
    done_nxt_s      = done_r;
    divcnt_nxt_s    = divcnt_r;
    tick_nxt_s      = 1'b0;
    if (soft_rst_r) begin
      state_nxt_s     = S_HOLD;
      cnt_nxt_s       = {CNT_W{1'b0}};
      rst_n_out_nxt_s = 1'b0;
      en_nxt_s        = {N_CH{1'b0}};
      done_nxt_s      = 1'b0;
    end else begin
      case (state_r)
        S_HOLD: begin
          rst_n_out_nxt_s = 1'b0;
          en_nxt_s        = {N_CH{1'b0}};
          if (cnt_r == CNT_W'(RST_HOLD - 1)) begin
            rst_n_out_nxt_s = 1'b1;
            cnt_nxt_s       = {CNT_W{1'b0}};
            state_nxt_s     = S_WAIT;
          end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
          end
        end
        S_WAIT: begin
          for (int k = 0; k < N_CH; k++) begin
            if (cnt_r == CNT_W'(EN_DELAY - 1 + k * EN_STAGGER)) begin
              en_nxt_s[k] = 1'b1;
            end else begin
              en_nxt_s[k] = en_r[k];
            end
          end
          // cnt stops at the last offset, so it saturates through S_RUN
          if (cnt_r == CNT_W'(LAST)) begin
            done_nxt_s  = 1'b1;
            state_nxt_s = S_RUN;
          end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
          end
        end
        S_RUN: begin
          state_nxt_s = S_RUN;
        end
        default: begin
          state_nxt_s     = S_HOLD;
          cnt_nxt_s       = {CNT_W{1'b0}};
          rst_n_out_nxt_s = 1'b0;
          en_nxt_s        = {N_CH{1'b0}};
          done_nxt_s      = 1'b0;
        end
      endcase
    end
    if (soft_rst_r || !en_r[0]) begin
      divcnt_nxt_s = {DIV_W{1'b0}};
      tick_nxt_s   = 1'b0;
    end else if (divcnt_r == DIV_W'(DIV - 1)) begin
      divcnt_nxt_s = {DIV_W{1'b0}};
      tick_nxt_s   = 1'b1;
    end else begin
      divcnt_nxt_s = divcnt_r + DIV_W'(1);
      tick_nxt_s   = 1'b0;
    end
  end

  // State and output registers, cleared by the synchronised reset
  always_ff @(posedge clk or negedge rst_sync_s) begin
    if (!rst_sync_s) begin
      soft_rst_r  <= 1'b0;
      state_r     <= S_HOLD;
      cnt_r       <= {CNT_W{1'b0}};
      divcnt_r    <= {DIV_W{1'b0}};
      rst_n_out_r <= 1'b0;
      en_r        <= {N_CH{1'b0}};
      tick_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      soft_rst_r  <= soft_rst;
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      divcnt_r    <= divcnt_nxt_s;
      rst_n_out_r <= rst_n_out_nxt_s;
      en_r        <= en_nxt_s;
      tick_r      <= tick_nxt_s;
      done_r      <= done_nxt_s;
    end
  end

  assign rst_n_out = rst_n_out_r;
  assign en        = en_r;
  assign tick      = tick_r;
  assign done      = done_r;

endmodule

// File: tb/tb_ck_rst_seq.sv
// Self-checking bench for ck_rst_seq: three parameter sets driven by shared
// directed and random reset/soft-reset stimulus, checked against a timeline model.
module tb_ck_rst_seq;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       soft_rst = 1'b0;

  logic       rno_a, tick_a, done_a;
  logic [1:0] en_a;
  logic       rno_b, tick_b, done_b;
  logic [2:0] en_b;
  logic       rno_c, tick_c, done_c;
  logic [3:0] en_c;

  int checks = 0;
  int errors = 0;

  // Model: edges seen with rst_n high, edges since the sequence origin,
  // and the soft reset sample that takes effect on the following edge.
  int hi_edges = 0;
  int rel = 0;
  bit soft_q = 1'b0;

  always #5 clk = ~clk;

  ck_rst_seq u_dut_a (
    .clk(clk), .rst_n(rst_n), .soft_rst(soft_rst),
    .rst_n_out(rno_a), .en(en_a), .tick(tick_a), .done(done_a)
  );

  ck_rst_seq #(.N_CH(3), .EN_STAGGER(3), .DIV(5), .RST_HOLD(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .soft_rst(soft_rst),
    .rst_n_out(rno_b), .en(en_b), .tick(tick_b), .done(done_b)
  );

  ck_rst_seq #(.N_CH(4), .EN_STAGGER(0), .DIV(1)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .soft_rst(soft_rst),
    .rst_n_out(rno_c), .en(en_c), .tick(tick_c), .done(done_c)
  );

  // Expected outputs as {tick, done, rst_n_out, en[3:0]} from event times.
  function automatic logic [6:0] model_out(input int rh, input int ed, input int n,
                                           input int s, input int dv);
    logic [6:0] r;
    int t_en0;
    r = 7'd0;
    if (hi_edges >= SYNC) begin
      t_en0 = rh + ed;
      r[4] = (rel >= rh);
      for (int k = 0; k < n; k++) r[k] = (rel >= t_en0 + k * s);
      r[5] = (rel >= t_en0 + (n - 1) * s);
      r[6] = (rel >= t_en0 + dv) && (((rel - t_en0) % dv) == 0);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (rel=%0d)", tag, obs, exp, rel);
    end
  endtask

  task automatic chk_dut(input string name, input logic rno, input logic [3:0] en,
                         input logic tk, input logic dn, input logic [6:0] e);
    chk({name, ".rst_n_out"}, {3'b000, rno}, {3'b000, e[4]});
    chk({name, ".en"},        en,            e[3:0]);
    chk({name, ".tick"},      {3'b000, tk},  {3'b000, e[6]});
    chk({name, ".done"},      {3'b000, dn},  {3'b000, e[5]});
  endtask

  task automatic compare_all();
    chk_dut("a", rno_a, {2'b00, en_a}, tick_a, done_a, model_out(5, 5, 2, 1, 2));
    chk_dut("b", rno_b, {1'b0, en_b},  tick_b, done_b, model_out(1, 5, 3, 3, 5));
    chk_dut("c", rno_c, en_c,          tick_c, done_c, model_out(5, 5, 4, 0, 1));
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      hi_edges = 0;
      soft_q = 1'b0;
    end else if (hi_edges < SYNC) begin
      hi_edges++;
      rel = 0;
      soft_q = 1'b0;
    end else begin
      rel = soft_q ? 0 : rel + 1;
      soft_q = soft_rst;
    end
    #2;
    compare_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Mid-cycle reset pulse; outputs must clear with no clock edge.
  task automatic pulse_rst();
    #1 rst_n = 1'b0;
    hi_edges = 0;
    soft_q = 1'b0;
    #1 compare_all();
    #2 rst_n = 1'b1;
  endtask

  initial begin
    steps(3);
    #3 rst_n = 1'b1;
    steps(22);

    soft_rst = 1'b1;
    step();
    soft_rst = 1'b0;
    steps(20);

    soft_rst = 1'b1;
    steps(6);
    soft_rst = 1'b0;
    steps(20);

    steps(3);
    pulse_rst();
    steps(24);

    for (int i = 0; i < 400; i++) begin
      soft_rst = ($urandom_range(0, 24) == 0);
      step();
      if ($urandom_range(0, 59) == 0) pulse_rst();
    end
    soft_rst = 1'b0;
    steps(25);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ck_rst_seq.md
Name: ck_rst_seq

Overview:
Synthesizable reset and enable sequencer for the VGA driver. It is the RTL successor to the bench-only clock/reset/enable stimulus.
- Synchronises the external asynchronous reset: assertion is asynchronous, deassertion is synchronous.
- Holds a distributed reset for a programmable time, then releases N_CH enables, staggered in time.
- Generates a pixel clock-enable tick by dividing clk by DIV.
- Accepts a synchronous soft reset that re-runs the sequence.

Parameters:
SYNC_STAGES, 2, number of reset synchroniser flops (legal values ≥2)
RST_HOLD, 5, clk cycles that rst_n_out stays low after the synchronised release (legal values ≥1)
EN_DELAY, 5, clk cycles from rst_n_out rising to en[0] rising (legal values ≥1)
N_CH, 2, number of enable channels (legal values ≥1)
EN_STAGGER, 1, clk cycles between en[k] and en[k+1] rising (legal values ≥0)
DIV, 2, tick period in clk cycles (legal values ≥1)

Ports:
clk  input  1  system clock, the single clock of the block
rst_n  input  1  reset, asynchronous, active-low
soft_rst  input  1  synchronous soft-reset request, active-high, level sensitive
rst_n_out  output  1  sequenced reset for downstream blocks, active-low
en  output  N_CH  per-channel enables
tick  output  1  one-cycle pixel clock-enable pulse
done  output  1  high when all en bits are high

Behaviour:
- Synchroniser: rst_n low clears all SYNC_STAGES flops asynchronously. The chain shifts in 1 on each clk rising edge. rst_sync is the last stage.
- Let E be the edge at which rst_sync becomes 1. E is the SYNC_STAGES-th rising edge after rst_n deasserts.
- rst_sync low (asynchronous) forces all of the following:
  - rst_n_out=0, en=0, tick=0, done=0
  - state=S_HOLD, cnt=0, divcnt=0
- All registers are clocked by clk. All outputs are registered.
- FSM states: S_HOLD, S_WAIT, S_RUN.
- S_HOLD:
  - rst_n_out=0, en=0.
  - cnt increments each edge.
  - At the edge where cnt==RST_HOLD-1: rst_n_out<=1, cnt<=0, go to S_WAIT. rst_n_out therefore rises at edge E+RST_HOLD.
- S_WAIT:
  - cnt increments each edge.
  - en[k] rises at the edge where cnt==EN_DELAY-1+k*EN_STAGGER.
  - When the last channel rises: done<=1, go to S_RUN. en[k] therefore rises at edge E+RST_HOLD+EN_DELAY+k*EN_STAGGER.
  - EN_STAGGER=0: all en bits rise on the same edge.
- S_RUN:
  - Outputs hold. Stays in S_RUN until soft_rst or rst_n.
- Tick divider:
  - divcnt is cleared while en[0]==0 and increments modulo DIV while en[0]==1.
  - tick<=1 on the edge where divcnt==DIV-1, otherwise tick<=0.
  - First tick is high after edge E+RST_HOLD+EN_DELAY+DIV, then repeats every DIV cycles.
  - DIV=1: tick is high every cycle after en[0] rises.
- soft_rst=1 sampled at an edge, in any state, at the next edge:
  - rst_n_out<=0, en<=0, tick<=0, done<=0, divcnt<=0
  - cnt<=0, state<=S_HOLD
- soft_rst held high: S_HOLD with cnt held at 0. Counting resumes on the first edge with soft_rst low.
- soft_rst has lower priority than rst_n. rst_n asserted mid-sequence aborts immediately and asynchronously; there is no glitch on rst_n_out.
- cnt width is $clog2 of the maximum of RST_HOLD and EN_DELAY+(N_CH-1)*EN_STAGGER, plus 1. divcnt width is $clog2(DIV)+1.
- cnt saturates in S_RUN (no wrap).

Decomposition:
- Package ck_rst_pkg contains:
  - state encoding: S_HOLD=2'd0, S_WAIT=2'd1, S_RUN=2'd2, width 2
  - a width helper function
- Sub-module rst_sync, parametrised by SYNC_STAGES. Ports: clk, rst_n in; rst_sync out.
- The FSM, counters and divider live in ck_rst_seq.

Test Plan:
- Defaults; rst_n low until just after edge 0 -> E=2, rst_n_out rises at edge 7, en[0] at 12, en[1] at 13, done=1 at 13; tick high after edges 14, 16, 18.
- rst_n pulsed low for 3 ns at edge 15 (asynchronous) -> all outputs 0 within that cycle with no clk edge needed; sequence restarts from the new E.
- soft_rst high for 1 cycle at edge 20 in S_RUN -> all outputs 0 after edge 21; rst_n_out rises at edge 26; en[0] at 31, en[1] at 32.
- soft_rst held high from edge 9 to edge 14 -> rst_n_out stays 0; it rises 5 edges after the first low sample of soft_rst.
- N_CH=4, EN_STAGGER=0, DIV=1 -> all en bits rise on the same edge as done; tick is high every cycle from the next edge.
- N_CH=3, EN_STAGGER=3, DIV=5, RST_HOLD=1 -> en spacing of 3 cycles; tick period 5 with exactly one-cycle high pulses; rst_n_out rises at edge E+1.
